// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: register offsets within the I/O window
// and bit positions inside the status register.
package mmio_pkg;

   localparam logic [7:0] MMIO_UART_CTRL = 8'h00;
   localparam logic [7:0] MMIO_UART_RX   = 8'h04;
   localparam logic [7:0] MMIO_UART_TX   = 8'h08;
   localparam logic [7:0] MMIO_CYCLE_CNT = 8'h10;
   localparam logic [7:0] MMIO_INST_CNT  = 8'h14;
   localparam logic [7:0] MMIO_CNT_RST   = 8'h18;

   localparam int STAT_TX_FREE  = 0;
   localparam int STAT_RX_AVAIL = 1;

endpackage

// File: rtl/mmio_rx_fifo.sv
// Small synchronous circular FIFO buffering received UART bytes.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module mmio_rx_fifo
   import mmio_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   // NOTE: the storage array has no reset; count alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO responder exposing UART RX/TX, status and cycle/instruction counters.
// Define MMIO_RX_FIFO_EN to replace the single RX holding register with a FIFO.
module mmio_uart_ctrl
   import mmio_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
   parameter int          RX_FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  we,
   input  logic        re,
   input  logic        inst_retire,
   output logic [31:0] rdata,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   logic        sel;
   logic        is_store;
   logic        rd_sel;
   logic [7:0]  off;
   logic        rx_push;
   logic        rx_pop;
   logic        rx_full;
   logic        rx_empty;
   logic [7:0]  rx_head;
   logic        tx_load;
   logic        cnt_clr;
   logic [31:0] cycle_cnt;
   logic [31:0] inst_cnt;
   logic [31:0] rd_val;

   // A store wins over a simultaneous load, so a load is only honoured with we == 0.
   assign sel      = (addr[31:28] == MMIO_BASE[31:28]);
   assign is_store = |we;
   assign off      = addr[7:0];
   assign rd_sel   = sel & re & ~is_store;

   assign rx_ready = rst & ~rx_full;
   assign rx_push  = rx_valid & rx_ready;
   assign rx_pop   = rd_sel & (off == MMIO_UART_RX) & ~rx_empty;
   assign tx_load  = sel & we[0] & (off == MMIO_UART_TX) & ~tx_valid;
   assign cnt_clr  = sel & is_store & (off == MMIO_CNT_RST);

`ifdef MMIO_RX_FIFO_EN
   logic unused_ok;
   assign unused_ok = ^{wdata[31:8], addr[27:8]};

   mmio_rx_fifo #(
      .DEPTH (RX_FIFO_DEPTH),
      .WIDTH (8)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .din   (rx_data),
      .pop   (rx_pop),
      .full  (rx_full),
      .empty (rx_empty),
      .head  (rx_head)
   );
`else
   logic unused_ok;
   logic rx_hold_valid;
   logic [7:0] rx_hold;
   assign unused_ok = ^{wdata[31:8], addr[27:8], RX_FIFO_DEPTH[0]};

   // Push needs !full and pop needs !empty, so they never coincide on one register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_hold_valid <= 1'b0;
         rx_hold       <= '0;
      end else if (rx_push) begin
         rx_hold_valid <= 1'b1;
         rx_hold       <= rx_data;
      end else if (rx_pop) begin
         rx_hold_valid <= 1'b0;
      end
   end

   assign rx_full  = rx_hold_valid;
   assign rx_empty = ~rx_hold_valid;
   assign rx_head  = rx_hold;
`endif

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      rd_val = '0;
      case (off)
         MMIO_UART_CTRL: begin
            rd_val[STAT_TX_FREE]  = ~tx_valid;
            rd_val[STAT_RX_AVAIL] = ~rx_empty;
         end
         MMIO_UART_RX:   rd_val[7:0] = rx_empty ? 8'h00 : rx_head;
         MMIO_CYCLE_CNT: rd_val = cycle_cnt;
         MMIO_INST_CNT:  rd_val = inst_cnt;
         default:        rd_val = '0;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         cycle_cnt <= '0;
         inst_cnt  <= '0;
         rdata     <= '0;
      end else begin
         if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
         end else if (tx_load) begin
            tx_valid <= 1'b1;
            tx_data  <= wdata[7:0];
         end

         if (cnt_clr) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
         end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            inst_cnt  <= inst_cnt + {31'd0, inst_retire};
         end

         // Any load request refreshes rdata; stores and foreign loads leave zero behind.
         if (re) rdata <= rd_sel ? rd_val : '0;
      end
   end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Self-checking bench for mmio_uart_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the register map.
module tb_mmio_uart_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  we;
   logic        re;
   logic        inst_retire;
   logic [31:0] rdata;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

`ifdef MMIO_RX_FIFO_EN
   localparam int RX_CAP = 4;
`else
   localparam int RX_CAP = 1;
`endif

   mmio_uart_ctrl #(
      .MMIO_BASE     (32'h8000_0000),
      .RX_FIFO_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .addr        (addr),
      .wdata       (wdata),
      .we          (we),
      .re          (re),
      .inst_retire (inst_retire),
      .rdata       (rdata),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0]  m_q [$];
   logic        m_txv;
   logic [7:0]  m_txd;
   logic [31:0] m_cyc;
   logic [31:0] m_ins;
   logic [31:0] m_rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply the register-map rules to the inputs present at this edge.
   task automatic model_edge();
      logic        sel;
      logic        st;
      logic        ld;
      logic        ready;
      logic        pop;
      logic [7:0]  off;
      logic [31:0] rv;
      if (!rst) begin
         m_q.delete();
         m_txv = 1'b0;
         m_txd = 8'h00;
         m_cyc = 32'd0;
         m_ins = 32'd0;
         m_rd  = 32'd0;
         return;
      end
      sel   = (addr[31:28] == 4'h8);
      st    = (we != 4'd0);
      ld    = re && !st;
      off   = addr[7:0];
      ready = (m_q.size() < RX_CAP);
      pop   = 1'b0;
      rv    = 32'd0;
      if (ld && sel) begin
         case (off)
            8'h00: rv = {30'd0, m_q.size() != 0, !m_txv};
            8'h04: if (m_q.size() != 0) begin rv = {24'd0, m_q[0]}; pop = 1'b1; end
            8'h10: rv = m_cyc;
            8'h14: rv = m_ins;
            default: rv = 32'd0;
         endcase
      end
      if (re) m_rd = (ld && sel) ? rv : 32'd0;
      if (pop) void'(m_q.pop_front());
      if (rx_valid && ready) m_q.push_back(rx_data);
      if (m_txv && tx_ready) m_txv = 1'b0;
      else if (!m_txv && sel && we[0] && off == 8'h08) begin
         m_txv = 1'b1;
         m_txd = wdata[7:0];
      end
      if (sel && st && off == 8'h18) begin
         m_cyc = 32'd0;
         m_ins = 32'd0;
      end else begin
         m_cyc = m_cyc + 32'd1;
         m_ins = m_ins + {31'd0, inst_retire};
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("rdata", rdata, m_rd);
      check("tx_valid", {31'd0, tx_valid}, {31'd0, m_txv});
      check("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
      check("rx_ready", {31'd0, rx_ready}, {31'd0, rst && (m_q.size() < RX_CAP)});
   endtask

   task automatic idle();
      addr  = 32'h0000_0000;
      wdata = 32'd0;
      we    = 4'd0;
      re    = 1'b0;
   endtask

   task automatic req(input logic [7:0] off, input logic [3:0] w, input logic r, input logic [31:0] d);
      addr  = {4'h8, 20'h00000, off};
      we    = w;
      re    = r;
      wdata = d;
   endtask

   logic [7:0] offs [8];

   initial begin
      offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C};
      rst = 1'b0;
      idle();
      inst_retire = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      tx_ready = 1'b0;

      // Reset state
      step();
      step();
      check("rst_rdata", rdata, 32'd0);
      check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      rst = 1'b1;

      // Counters after 5 idle cycles, 3 retiring
      for (int i = 0; i < 5; i++) begin
         inst_retire = (i < 3);
         step();
      end
      inst_retire = 1'b0;
      req(8'h10, 4'd0, 1'b1, 32'd0); step(); check("cyc_5", rdata, 32'd5);
      req(8'h14, 4'd0, 1'b1, 32'd0); step(); check("ins_3", rdata, 32'd3);
      req(8'h00, 4'd0, 1'b1, 32'd0); step(); check("status_idle", rdata, 32'h1);

      // TX hold for 4 cycles, second store dropped
      req(8'h08, 4'b0001, 1'b0, 32'h41); step();
      check("tx_set", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h41});
      for (int i = 0; i < 4; i++) begin
         if (i == 1) req(8'h08, 4'b0001, 1'b0, 32'h42);
         else idle();
         step();
         check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h41});
      end
      idle();
      tx_ready = 1'b1; step();
      check("tx_clear", {31'd0, tx_valid}, 32'd0);
      tx_ready = 1'b0;

      // Single RX byte
      rx_valid = 1'b1; rx_data = 8'h5A; step();
      rx_valid = 1'b0;
      req(8'h00, 4'd0, 1'b1, 32'd0); step(); check("status_rx", rdata, 32'h3);
      req(8'h04, 4'd0, 1'b1, 32'd0); step(); check("rx_5a", rdata, 32'h5A);
      req(8'h00, 4'd0, 1'b1, 32'd0); step(); check("status_after_pop", rdata, 32'h1);
      req(8'h04, 4'd0, 1'b1, 32'd0); step(); check("rx_empty", rdata, 32'h0);
      idle();

`ifdef MMIO_RX_FIFO_EN
      // FIFO fill, back-pressure and ordered drain
      rx_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         rx_data = 8'(i);
         step();
      end
      check("fifo_full", {31'd0, rx_ready}, 32'd0);
      rx_data = 8'h05;
      for (int i = 1; i <= 5; i++) begin
         req(8'h04, 4'd0, 1'b1, 32'd0);
         step();
         check("fifo_pop", rdata, 32'(i));
         if (i == 2) rx_valid = 1'b0;
      end
`else
      // Holding register back-pressure
      rx_valid = 1'b1; rx_data = 8'h11; step();
      check("hold_full", {31'd0, rx_ready}, 32'd0);
      rx_data = 8'h22; step();
      rx_valid = 1'b0;
      req(8'h04, 4'd0, 1'b1, 32'd0); step(); check("hold_pop", rdata, 32'h11);
`endif
      idle();

      // Cycle counter wrap and clear priority
      force dut.cycle_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.cycle_cnt;
      m_cyc = 32'hFFFF_FFFF;
      step();
      req(8'h10, 4'd0, 1'b1, 32'd0); step(); check("cyc_wrap", rdata, 32'd0);
      inst_retire = 1'b1;
      req(8'h18, 4'b1111, 1'b0, 32'd0); step();
      inst_retire = 1'b0;
      req(8'h10, 4'd0, 1'b1, 32'd0); step(); check("cyc_clr", rdata, 32'd0);
      req(8'h14, 4'd0, 1'b1, 32'd0); step(); check("ins_clr", rdata, 32'd0);

      // Reset mid-transaction
      req(8'h08, 4'b0001, 1'b0, 32'h77); step();
      req(8'h10, 4'd0, 1'b1, 32'd0);
      rx_valid = 1'b1; rx_data = 8'hAA; step();
      rx_data = 8'hBB; step();
      rx_valid = 1'b0;
      idle();
      rst = 1'b0; step();
      check("mid_rst_tx", {31'd0, tx_valid}, 32'd0);
      check("mid_rst_rdata", rdata, 32'd0);
      rst = 1'b1;
      req(8'h00, 4'd0, 1'b1, 32'd0); step(); check("mid_rst_status", rdata, 32'h1);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [3:0] hi;
         logic [7:0] off;
         rst  = ($urandom_range(0, 99) != 0);
         hi   = ($urandom_range(0, 3) != 0) ? 4'h8 : 4'($urandom_range(0, 7));
         off  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : offs[$urandom_range(0, 7)];
         addr = {hi, 20'($urandom), off};
         we   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
         re   = 1'($urandom_range(0, 1));
         wdata       = $urandom;
         rx_valid    = 1'($urandom_range(0, 1));
         rx_data     = 8'($urandom);
         tx_ready    = ($urandom_range(0, 2) == 0);
         inst_retire = 1'($urandom_range(0, 1));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mmio_uart_ctrl.md
# mmio_uart_ctrl

Memory-mapped I/O responder on the CPU data-memory path. It decodes EX-stage load/store requests in the I/O window and exposes the UART receiver and transmitter valid/ready ports as status, RX-data and TX-data registers. It also provides the cycle and retired-instruction counters. Read data is registered so it lines up with the synchronous dmem read at the WB-stage load mux.

## Interface
- MMIO_BASE, 32'h8000_0000: I/O window base. A request is selected when addr[31:28] == MMIO_BASE[31:28].
- RX_FIFO_DEPTH, 4: RX buffer depth, power of two ≥2. Used only when MMIO_RX_FIFO_EN is defined.

- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-low reset
- addr  in  32  byte address of the request (ALU result)
- wdata  in  32  store data, already lane-shifted
- we  in  4  byte write enables; any bit set means store
- re  in  1  load request
- inst_retire  in  1  one instruction retires this cycle
- rdata  out  32  load data, registered
- rx_data  in  8  byte from uart_receiver
- rx_valid  in  1  receiver has a byte
- rx_ready  out  1  block accepts the byte
- tx_data  out  8  byte to uart_transmitter
- tx_valid  out  1  byte pending
- tx_ready  in  1  transmitter accepts

## Operation
Register map (offset = addr[7:0]):
- 0x00, RO, status: bit0 = tx_free (!tx_valid), bit1 = rx_avail (buffer non-empty), other bits 0.
- 0x04, RO, RX data: [7:0] = head byte, [31:8] = 0. A selected load pops one entry. A load while empty returns 0 and changes no state.
- 0x08, WO, TX data: a store with we[0]=1 and tx_free=1 loads wdata[7:0] and sets tx_valid. A store while tx_valid=1 is dropped; software polls bit0 first.
- 0x10, RO: cycle counter.
- 0x14, RO: instruction counter.
- 0x18, WO: any store clears both counters.

Access rules:
- Unmapped offsets and unselected addresses: reads return 0, writes are ignored, no side effects.
- re and we both set: treated as a store, rdata = 0.

TX:
- tx_valid stays high until the cycle where tx_valid & tx_ready; it clears on the next edge.
- tx_data is held stable while tx_valid is high.

RX:
- rx_ready = rst & !rx_full.
- A byte is captured on rx_valid & rx_ready.

Counters:
- Cycle counter: +1 every cycle.
- Instruction counter: +1 when inst_retire is high.
- Both are 32-bit and wrap from 32'hFFFF_FFFF to 0.
- Clear has priority over increment: after a clear store, both read 0 in the following cycle.

## Timing
- Load latency is 1 cycle: rdata reflects the register value sampled at the request edge and is valid in the cycle after re.
- rdata holds until the next request, and becomes 0 after an unselected or unmapped load.
- Pop and status update take effect at the request edge. A status read in the cycle right after a pop shows the updated state.
- A TX store at edge N gives tx_valid=1 from N+1. A handshake at edge M gives tx_valid=0 and tx_free=1 from M+1.
- RX push and pop in the same cycle (non-empty): occupancy is unchanged and the head advances.
- Reset (rst low at an edge) gives: rdata=0, tx_valid=0, tx_data=0, RX buffer empty, both counters 0, rx_ready=0 while asserted.
  - Reset mid-transaction drops any pending TX byte and any buffered RX bytes.

## Configuration
- MMIO_RX_FIFO_EN defined:
  - RX buffer is a RX_FIFO_DEPTH-entry circular FIFO with wrap-around read/write pointers.
  - rx_full when count == RX_FIFO_DEPTH.
  - A push while full cannot occur, because rx_ready is low.
- MMIO_RX_FIFO_EN undefined:
  - RX buffer is a single holding register plus a full flag.
  - rx_ready is low while the flag is set, so the receiver back-pressures until software reads 0x04.

## Structure
- Shared package mmio_pkg holds:
  - Offset constants MMIO_UART_CTRL, MMIO_UART_RX, MMIO_UART_TX, MMIO_CYCLE_CNT, MMIO_INST_CNT, MMIO_CNT_RST.
  - Status bit positions.
- One sub-module, mmio_rx_fifo: parameterized sync FIFO with push/pop/full/empty/head. It is instantiated only under MMIO_RX_FIFO_EN.
- Top level contains address decode, TX holding register, counters and the rdata register.

## Test plan
- Reset, then 5 idle cycles with inst_retire=1 for 3 of them, then load 0x10 and 0x14 -> rdata = 5 and 3 (sampled at the request edge), status 0x00 reads 32'h1.
- Store 32'h41 to 0x08 with tx_ready=0 for 4 cycles, then 1 -> tx_data=8'h41 and tx_valid held for 4 cycles, cleared the cycle after the handshake. A second store during the hold is dropped.
- Receiver pushes 8'h5A -> status reads 32'h3, load 0x04 returns 32'h5A, the next status reads 32'h1, a second 0x04 load returns 0.
- With MMIO_RX_FIFO_EN: push 8'h01..8'h05 -> rx_ready drops after the 4th byte. Four loads return 1, 2, 3, 4 in order, and byte 5 is accepted after the first pop.
- Preload the cycle counter to 32'hFFFF_FFFF, then one cycle -> reads 0. Store to 0x18 -> both counters read 0 next cycle even with inst_retire=1.
- Assert rst low mid TX hold and with 2 RX bytes buffered -> tx_valid=0, status reads 32'h1, rdata=0 after the reset edge.
